// File: rtl/tof_pkg.sv
// Shared types and default timing constants for the time-of-flight ping scheduler.
package tof_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StBurst   = 3'd1,
        StBlank   = 3'd2,
        StListen  = 3'd3,
        StHoldoff = 3'd4
    } tof_state_t;

    localparam int unsigned     DEFAULT_BURST_CYCLES   = 2000;
    localparam int unsigned     DEFAULT_BLANK_CYCLES   = 50000;
    localparam longint unsigned DEFAULT_MAX_WINDOW     = 500000;
    localparam int unsigned     DEFAULT_HOLDOFF_CYCLES = 100000;

    localparam int unsigned SPEED_OF_SOUND_CM_S = 34300;
    localparam int unsigned CLK_HZ              = 100_000_000;

    // Round-trip flight time in clock cycles to one-way distance in millimetres.
    function automatic logic [31:0] tof_cycles_to_mm(input logic [31:0] cycles);
        logic [63:0] num;
        num = 64'(cycles) * 64'(SPEED_OF_SOUND_CM_S) * 64'd10;
        return 32'(num / (64'd2 * 64'(CLK_HZ)));
    endfunction

endpackage

// File: rtl/tof_window_counter.sv
// Clear/enable up-counter with registered output; clear has priority over enable.
module tof_window_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tof_ping_scheduler.sv
// Ultrasonic ping sequencer: burst, ringdown blanking, echo listen window, holdoff.
// Define TOF_ECHO_DEBOUNCE_EN to require echo_in high on two consecutive listen cycles.
module tof_ping_scheduler
    import tof_pkg::*;
#(
    parameter int unsigned     BURST_CYCLES   = DEFAULT_BURST_CYCLES,
    parameter int unsigned     BLANK_CYCLES   = DEFAULT_BLANK_CYCLES,
    parameter longint unsigned MAX_WINDOW     = DEFAULT_MAX_WINDOW,
    parameter int unsigned     HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        continuous_in,
    input  logic        abort_in,
    input  logic        echo_in,
    output logic        tx_en_out,
    output logic        listen_out,
    output logic [31:0] time_since_emission_out,
    output logic [31:0] tof_out,
    output logic        valid_out,
    output logic        hit_out,
    output logic        busy_out
);

    localparam bit          SkipBlank   = (BLANK_CYCLES <= BURST_CYCLES);
    localparam int unsigned ListenStart = SkipBlank ? BURST_CYCLES : BLANK_CYCLES;
    localparam logic [31:0] BurstLast   = 32'(BURST_CYCLES - 1);
    localparam logic [31:0] BlankLast   = 32'(BLANK_CYCLES - 1);
    localparam logic [31:0] MaxLast     = 32'(MAX_WINDOW - 1);
    localparam logic [31:0] MaxWindow32 = 32'(MAX_WINDOW);
    localparam logic [31:0] HoldLast    = 32'(HOLDOFF_CYCLES - 1);

    if (MAX_WINDOW >= 64'h1_0000_0000) begin : g_chk_max_width
        $fatal(1, "MAX_WINDOW must be below 2^32");
    end
    if (MAX_WINDOW <= 64'(ListenStart)) begin : g_chk_max_reach
        $fatal(1, "MAX_WINDOW must exceed the start of the listen window");
    end
    if (BURST_CYCLES == 0 || BLANK_CYCLES == 0 || HOLDOFF_CYCLES == 0) begin : g_chk_nonzero
        $fatal(1, "BURST_CYCLES, BLANK_CYCLES and HOLDOFF_CYCLES must be non-zero");
    end

    tof_state_t  state_q;
    logic        tx_en_q;
    logic        listen_q;
    logic        busy_q;
    logic        valid_q;
    logic        hit_q;
    logic [31:0] tof_q;

    logic [31:0] count;
    logic [31:0] hold_count;
    logic        echo_ok;
    logic [31:0] echo_tof;

    logic start_go;
    logic rearm;
    logic echo_hit;
    logic timeout;
    logic result;
    logic cnt_clear;
    logic cnt_en;
    logic hold_clear;
    logic hold_en;
    logic hold_done;

`ifdef TOF_ECHO_DEBOUNCE_EN
    // Remembers an echo seen in the previous cycle only if that cycle was a listen cycle.
    logic echo_prev_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            echo_prev_q <= 1'b0;
        end else begin
            echo_prev_q <= (state_q == StListen) && echo_in;
        end
    end

    assign echo_ok  = echo_in && echo_prev_q;
    assign echo_tof = count - 32'd1;
`else
    assign echo_ok  = echo_in;
    assign echo_tof = count;
`endif

    always_comb begin
        start_go   = 1'b0;
        rearm      = 1'b0;
        echo_hit   = 1'b0;
        timeout    = 1'b0;
        cnt_en     = 1'b0;
        hold_en    = 1'b0;
        hold_done  = (hold_count == HoldLast);
        unique case (state_q)
            StIdle:    start_go = start_in || continuous_in;
            StHoldoff: begin
                hold_en = 1'b1;
                rearm   = hold_done && continuous_in && !abort_in;
            end
            StListen:  begin
                echo_hit = echo_ok;
                timeout  = (count == MaxLast);
                cnt_en   = !abort_in;
            end
            StBurst, StBlank: cnt_en = !abort_in;
            default: ;
        endcase
        // Abort cancels the ping outright; echo beats timeout further down in the FSM.
        result     = (echo_hit || timeout) && !abort_in;
        cnt_clear  = start_go || rearm;
        hold_clear = result;
    end

    tof_window_counter #(
        .WIDTH (32)
    ) u_flight_counter (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (count)
    );

    tof_window_counter #(
        .WIDTH (32)
    ) u_holdoff_counter (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (hold_clear),
        .enable (hold_en),
        .count  (hold_count)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            tx_en_q  <= 1'b0;
            listen_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            tof_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            if (state_q != StIdle && abort_in) begin
                state_q  <= StIdle;
                tx_en_q  <= 1'b0;
                listen_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_go) begin
                            state_q <= StBurst;
                            tx_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    StBurst: begin
                        if (count == BurstLast) begin
                            tx_en_q <= 1'b0;
                            if (SkipBlank) begin
                                state_q  <= StListen;
                                listen_q <= 1'b1;
                            end else begin
                                state_q <= StBlank;
                            end
                        end
                    end
                    StBlank: begin
                        if (count == BlankLast) begin
                            state_q  <= StListen;
                            listen_q <= 1'b1;
                        end
                    end
                    StListen: begin
                        if (echo_hit) begin
                            state_q  <= StHoldoff;
                            listen_q <= 1'b0;
                            valid_q  <= 1'b1;
                            hit_q    <= 1'b1;
                            tof_q    <= echo_tof;
                        end else if (timeout) begin
                            state_q  <= StHoldoff;
                            listen_q <= 1'b0;
                            valid_q  <= 1'b1;
                            hit_q    <= 1'b0;
                            tof_q    <= MaxWindow32;
                        end
                    end
                    StHoldoff: begin
                        if (hold_done) begin
                            if (continuous_in) begin
                                state_q <= StBurst;
                                tx_en_q <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        tx_en_q  <= 1'b0;
                        listen_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_en_out               = tx_en_q;
    assign listen_out              = listen_q;
    assign busy_out                = busy_q;
    assign valid_out               = valid_q;
    assign hit_out                 = hit_q;
    assign tof_out                 = tof_q;
    assign time_since_emission_out = count;

endmodule
